// File: rtl/rggen_atomic_register_common_if.sv
// Register bus handshake for rggen_atomic_register_common.
// The master issues requests; the slave (the register) answers with ready, status and read data.
interface rggen_atomic_register_common_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     i_register_valid;
  logic [1:0]               i_register_access;
  logic [ADDRESS_WIDTH-1:0] i_register_address;
  logic [BUS_WIDTH-1:0]     i_register_write_data;
  logic [BUS_WIDTH-1:0]     i_register_strobe;
  logic                     o_register_active;
  logic                     o_register_ready;
  logic [1:0]               o_register_status;
  logic [BUS_WIDTH-1:0]     o_register_read_data;

  modport master (
    output i_register_valid, i_register_access, i_register_address,
           i_register_write_data, i_register_strobe,
    input  o_register_active, o_register_ready, o_register_status, o_register_read_data
  );

  modport slave (
    input  i_register_valid, i_register_access, i_register_address,
           i_register_write_data, i_register_strobe,
    output o_register_active, o_register_ready, o_register_status, o_register_read_data
  );
endinterface

// File: rtl/rggen_atomic_register_common.sv
// Multi-word register front end: address decode, ready latency, write staging so that
// wide registers update in one shot, and read snapshots so upper words are coherent.
module rggen_atomic_register_common #(
  parameter bit READABLE             = 1'b1,
  parameter bit WRITABLE             = 1'b1,
  parameter int ADDRESS_WIDTH        = 8,
  parameter int OFFSET_ADDRESS       = 0,
  parameter int BUS_WIDTH            = 32,
  parameter int DATA_WIDTH           = BUS_WIDTH,
  parameter bit ATOMIC_WRITE         = 1'b1,
  parameter bit ATOMIC_READ          = 1'b1,
  parameter int WAIT_CYCLES          = 0,
  parameter bit USE_ADDITIONAL_MATCH = 1'b0,
  parameter bit USE_ADDITIONAL_MASK  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rggen_atomic_register_common_if.slave register_if,
  input  logic                  i_additional_match,
  input  logic [BUS_WIDTH-1:0]  i_additional_mask,
  output logic                  o_bit_field_write_valid,
  output logic                  o_bit_field_read_valid,
  output logic [DATA_WIDTH-1:0] o_bit_field_mask,
  output logic [DATA_WIDTH-1:0] o_bit_field_write_data,
  input  logic [DATA_WIDTH-1:0] i_bit_field_read_data,
  input  logic [DATA_WIDTH-1:0] i_bit_field_value
);
  localparam int WORDS = DATA_WIDTH / BUS_WIDTH;
  localparam int LSB   = $clog2(BUS_WIDTH / 8);
  localparam bit ATOMIC_WRITE_EN = ATOMIC_WRITE && (WORDS > 1);
  localparam bit ATOMIC_READ_EN  = ATOMIC_READ && (WORDS > 1);
  // The request cycle itself is the first wait cycle, so ready lands WAIT_CYCLES after valid.
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e                state_q;
  logic [3:0]            count_q;
  logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
  logic [DATA_WIDTH-1:0] stage_mask_q, stage_mask_d;
  logic [DATA_WIDTH-1:0] snapshot_q, snapshot_d;
  logic                  snap_valid_q, snap_valid_d;

  logic [WORDS-1:0]      hit;
  logic                  write_access, access_ok, extra_ok, request, ready;
  logic [BUS_WIDTH-1:0]  word_mask, read_data, live_lane, snap_lane;
  logic [DATA_WIDTH-1:0] lane_mask, lane_full, write_rep;
  logic                  unused_bits;

  assign write_access = register_if.i_register_access[0];
  assign access_ok    = write_access ? WRITABLE : READABLE;
  assign extra_ok     = USE_ADDITIONAL_MATCH ? i_additional_match : 1'b1;
  assign word_mask    = register_if.i_register_strobe &
                        (USE_ADDITIONAL_MASK ? i_additional_mask : {BUS_WIDTH{1'b1}});
  assign write_rep    = {WORDS{register_if.i_register_write_data}};
  assign unused_bits  = ^{register_if.i_register_access[1], register_if.i_register_address};

  for (genvar k = 0; k < WORDS; k++) begin : g_match
    localparam logic [ADDRESS_WIDTH-1:0] WORD_ADDR =
      ADDRESS_WIDTH'(OFFSET_ADDRESS + k * (BUS_WIDTH / 8));
    assign hit[k] = (register_if.i_register_address[ADDRESS_WIDTH-1:LSB] ==
                     WORD_ADDR[ADDRESS_WIDTH-1:LSB]) && access_ok && extra_ok;
  end

  assign request = register_if.i_register_valid && (|hit);

  always_comb begin
    ready = 1'b0;
    if (!i_rst) begin
      case (state_q)
        ST_IDLE: ready = request && (WAIT_CYCLES == 0);
        ST_WAIT: ready = request && (count_q == 4'd0);
        default: ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (request && (WAIT_CYCLES != 0)) begin
            state_q <= ST_WAIT;
            count_q <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!request || (count_q == 4'd0)) begin
            state_q <= ST_IDLE;
            count_q <= 4'd0;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= 4'd0;
        end
      endcase
    end
  end

  // Spread the current bus word into its lane of the full-width register.
  always_comb begin
    lane_mask = '0;
    lane_full = '0;
    live_lane = '0;
    snap_lane = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (hit[k]) begin
        lane_mask[k*BUS_WIDTH +: BUS_WIDTH] = word_mask;
        lane_full[k*BUS_WIDTH +: BUS_WIDTH] = '1;
        live_lane = i_bit_field_read_data[k*BUS_WIDTH +: BUS_WIDTH];
        snap_lane = snapshot_q[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_comb begin
    o_bit_field_write_valid = 1'b0;
    o_bit_field_read_valid  = 1'b0;
    o_bit_field_mask        = '0;
    o_bit_field_write_data  = '0;
    read_data               = '0;
    stage_data_d            = stage_data_q;
    stage_mask_d            = stage_mask_q;
    snapshot_d              = snapshot_q;
    snap_valid_d            = snap_valid_q;
    if (ready && write_access) begin
      if (!ATOMIC_WRITE_EN) begin
        o_bit_field_write_valid = 1'b1;
        o_bit_field_mask        = lane_mask;
        o_bit_field_write_data  = write_rep;
      end else if (hit[WORDS-1]) begin
        o_bit_field_write_valid = 1'b1;
        o_bit_field_mask        = stage_mask_q | lane_mask;
        o_bit_field_write_data  = (stage_data_q & ~lane_mask) | (write_rep & lane_mask);
        stage_mask_d            = '0;
      end else begin
        stage_data_d = (stage_data_q & ~lane_mask) | (write_rep & lane_mask);
        stage_mask_d = stage_mask_q | lane_mask;
      end
      if (o_bit_field_write_valid) begin
        snap_valid_d = 1'b0;
      end
    end else if (ready) begin
      if (ATOMIC_READ_EN && hit[0]) begin
        o_bit_field_read_valid = 1'b1;
        o_bit_field_mask       = '1;
        read_data              = live_lane;
        snapshot_d             = i_bit_field_read_data;
        snap_valid_d           = 1'b1;
      end else if (ATOMIC_READ_EN && snap_valid_q) begin
        read_data = snap_lane;
      end else begin
        o_bit_field_read_valid = 1'b1;
        o_bit_field_mask       = lane_full;
        read_data              = live_lane;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_data_q <= '0;
      stage_mask_q <= '0;
      snapshot_q   <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      stage_data_q <= stage_data_d;
      stage_mask_q <= stage_mask_d;
      snapshot_q   <= snapshot_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign register_if.o_register_active    = |hit;
  assign register_if.o_register_ready     = ready;
  assign register_if.o_register_status    = 2'b00;
  assign register_if.o_register_read_data = read_data;
endmodule

// File: tb/tb_rggen_atomic_register_common.sv
// Directed bench for a 64-bit atomic register on a 32-bit bus at 0x10 with two wait cycles.
// Expected transactions are queued at issue time and popped when ready is seen.
module tb_rggen_atomic_register_common;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          additionalMatch;
  logic [BW-1:0] additionalMask;
  logic          writeValid, readValid;
  logic [DW-1:0] fieldMask, fieldWriteData, fieldReadData, fieldValue, registerValue;

  always #5 clk = ~clk;

  rggen_atomic_register_common_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) regIf ();

  rggen_atomic_register_common #(
    .ADDRESS_WIDTH(AW), .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(BW), .DATA_WIDTH(DW),
    .WAIT_CYCLES(2)
  ) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .register_if            (regIf),
    .i_additional_match     (additionalMatch),
    .i_additional_mask      (additionalMask),
    .o_bit_field_write_valid(writeValid),
    .o_bit_field_read_valid (readValid),
    .o_bit_field_mask       (fieldMask),
    .o_bit_field_write_data (fieldWriteData),
    .i_bit_field_read_data  (fieldReadData),
    .i_bit_field_value      (fieldValue)
  );
  assign registerValue = fieldValue;

  typedef struct {
    logic          wr;
    logic          rd;
    logic          chkMask;
    logic [DW-1:0] mask;
    logic          chkWdata;
    logic [DW-1:0] wdata;
    logic [BW-1:0] rdata;
  } expTxn_t;

  expTxn_t expQueue[$];
  int checks = 0;
  int failures = 0;

  task automatic compare(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    expTxn_t e;
    e = expQueue.pop_front();
    compare({tag, "_wvalid"}, 64'(writeValid), 64'(e.wr));
    compare({tag, "_rvalid"}, 64'(readValid), 64'(e.rd));
    compare({tag, "_rdata"}, 64'(regIf.o_register_read_data), 64'(e.rdata));
    compare({tag, "_status"}, 64'(regIf.o_register_status), 64'd0);
    if (e.chkMask)  compare({tag, "_mask"}, fieldMask, e.mask);
    if (e.chkWdata) compare({tag, "_wdata"}, fieldWriteData, e.wdata);
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic applyStimulus(input string tag, input logic isWrite, input logic [AW-1:0] addr,
                               input logic [BW-1:0] wdata, input logic [BW-1:0] strobe,
                               input expTxn_t e);
    int cycles = 0;
    logic gotReady = 1'b0;
    expQueue.push_back(e);
    regIf.i_register_valid      = 1'b1;
    regIf.i_register_access     = isWrite ? 2'b01 : 2'b00;
    regIf.i_register_address    = addr;
    regIf.i_register_write_data = wdata;
    regIf.i_register_strobe     = strobe;
    while (!gotReady && cycles < 8) begin
      #1;
      if (regIf.o_register_ready) begin
        gotReady = 1'b1;
      end else begin
        compare({tag, "_early_valid"}, 64'({writeValid, readValid}), 64'd0);
        @(negedge clk);
        cycles++;
      end
    end
    compare({tag, "_ready"}, 64'(gotReady), 64'd1);
    if (gotReady) begin
      compare({tag, "_latency"}, 64'(cycles), 64'd2);
      checkOutput(tag);
    end else begin
      void'(expQueue.pop_front());
    end
    @(negedge clk);
    regIf.i_register_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic expTxn_t mk(input logic wr, input logic rd, input logic chkMask,
                                 input logic [DW-1:0] mask, input logic chkWdata,
                                 input logic [DW-1:0] wdata, input logic [BW-1:0] rdata);
    expTxn_t e;
    e.wr = wr; e.rd = rd; e.chkMask = chkMask; e.mask = mask;
    e.chkWdata = chkWdata; e.wdata = wdata; e.rdata = rdata;
    return e;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    additionalMatch = 1'b0;
    additionalMask = '0;
    fieldReadData = '0;
    fieldValue = 64'hFEEDFACE_0BADF00D;
    regIf.i_register_valid = 1'b0;
    regIf.i_register_access = 2'b00;
    regIf.i_register_address = 8'h00;
    regIf.i_register_write_data = '0;
    regIf.i_register_strobe = '0;
    repeat (3) @(negedge clk);
    #1;
    compare("reset_ready", 64'(regIf.o_register_ready), 64'd0);
    compare("reset_wvalid", 64'(writeValid), 64'd0);
    compare("reset_rvalid", 64'(readValid), 64'd0);
    compare("reset_rdata", 64'(regIf.o_register_read_data), 64'd0);
    compare("reg_value", registerValue === fieldValue ? 64'(dut.i_bit_field_value) : '0, 64'hFEEDFACE_0BADF00D);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    regIf.i_register_address = 8'h10; #1;
    compare("active_0x10", 64'(regIf.o_register_active), 64'd1);
    regIf.i_register_address = 8'h17; #1;
    compare("active_0x17", 64'(regIf.o_register_active), 64'd1);
    regIf.i_register_address = 8'h18; #1;
    compare("active_0x18", 64'(regIf.o_register_active), 64'd0);
    @(negedge clk);

    $display("[TB] atomic write pair");
    applyStimulus("w_lo", 1'b1, 8'h10, 32'h11223344, '1, mk(0, 0, 0, '0, 0, '0, '0));
    applyStimulus("w_hi", 1'b1, 8'h14, 32'hAABBCCDD, '1,
                  mk(1, 0, 1, '1, 1, 64'hAABBCCDD_11223344, '0));

    $display("[TB] repeated lower write before commit");
    applyStimulus("rw_a", 1'b1, 8'h10, 32'h11111111, '1, mk(0, 0, 0, '0, 0, '0, '0));
    applyStimulus("rw_b", 1'b1, 8'h10, 32'h22222222, 32'h0000FFFF, mk(0, 0, 0, '0, 0, '0, '0));
    applyStimulus("rw_c", 1'b1, 8'h14, 32'h33333333, 32'hFFFF0000,
                  mk(1, 0, 1, 64'hFFFF0000_FFFFFFFF, 1, 64'h33330000_11112222, '0));

    $display("[TB] atomic read with snapshot");
    fieldReadData = 64'h55667788_99AABBCC;
    applyStimulus("r_lo", 1'b0, 8'h10, '0, '0, mk(0, 1, 1, '1, 0, '0, 32'h99AABBCC));
    fieldReadData = '0;
    applyStimulus("r_hi", 1'b0, 8'h14, '0, '0, mk(0, 0, 0, '0, 0, '0, 32'h55667788));

    $display("[TB] request withdrawn during wait");
    regIf.i_register_valid = 1'b1;
    regIf.i_register_access = 2'b00;
    regIf.i_register_address = 8'h10;
    #1;
    compare("abort_c0_ready", 64'(regIf.o_register_ready), 64'd0);
    @(negedge clk);
    regIf.i_register_valid = 1'b0;
    #1;
    compare("abort_c1_ready", 64'(regIf.o_register_ready), 64'd0);
    compare("abort_c1_rvalid", 64'(readValid), 64'd0);
    @(negedge clk);
    applyStimulus("abort_after", 1'b0, 8'h14, '0, '0, mk(0, 0, 0, '0, 0, '0, 32'h55667788));

    $display("[TB] reset discards staging and pending wait");
    applyStimulus("st_lo", 1'b1, 8'h10, 32'hDEADBEEF, '1, mk(0, 0, 0, '0, 0, '0, '0));
    regIf.i_register_valid = 1'b1;
    regIf.i_register_access = 2'b01;
    regIf.i_register_address = 8'h14;
    regIf.i_register_write_data = 32'h12345678;
    regIf.i_register_strobe = '1;
    #1;
    compare("rstw_c0_ready", 64'(regIf.o_register_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compare("rstw_c1_ready", 64'(regIf.o_register_ready), 64'd0);
    compare("rstw_c1_wvalid", 64'(writeValid), 64'd0);
    @(negedge clk);
    #1;
    compare("rstw_c2_ready", 64'(regIf.o_register_ready), 64'd0);
    compare("rstw_c2_wvalid", 64'(writeValid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    regIf.i_register_valid = 1'b0;
    @(negedge clk);
    applyStimulus("post_rst", 1'b1, 8'h14, 32'h0000FFFF, '1,
                  mk(1, 0, 1, 64'hFFFFFFFF_00000000, 1, 64'h0000FFFF_00000000, '0));

    $display("[TB] write invalidates snapshot");
    fieldReadData = 64'h01234567_89ABCDEF;
    applyStimulus("snap_lo", 1'b0, 8'h10, '0, '0, mk(0, 1, 1, '1, 0, '0, 32'h89ABCDEF));
    applyStimulus("snap_w", 1'b1, 8'h14, 32'hCAFEF00D, '1,
                  mk(1, 0, 1, 64'hFFFFFFFF_00000000, 1, 64'hCAFEF00D_00000000, '0));
    applyStimulus("live_hi", 1'b0, 8'h14, '0, '0,
                  mk(0, 1, 1, 64'hFFFFFFFF_00000000, 0, '0, 32'h01234567));

    compare("queue_empty", 64'(expQueue.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
